// File: rtl/bram_stream_reader_if.sv
// -----------------------------------------------------------------------------
// bram_stream_reader_if
// Valid/ready word stream that carries RAM read data out of bram_stream_reader.
//   valid : word on data is valid (master -> slave)
//   ready : slave accepts the word this cycle (slave -> master)
//   data  : WIDTH-bit word (master -> slave)
//   last  : final word of a transfer (master -> slave)
// -----------------------------------------------------------------------------
interface bram_stream_reader_if #(
  parameter int WIDTH = 32
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
// Streams len consecutive words from a single-port block RAM, starting at
// base_addr and wrapping at DEPTH, onto a valid/ready stream. A two-entry
// buffer hides the RAM's one-cycle read latency and downstream backpressure,
// so one word per cycle is sustained.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   start              : command strobe, honoured only when idle
//   base_addr, len     : first word address and word count (0..DEPTH)
//   busy, done, err    : transfer in progress / completion pulse / reject pulse
//   mem_we, mem_addr,
//   mem_din, mem_dout  : RAM port (read-only use; we and din tied to 0)
//   m                  : output word stream (master side)
// -----------------------------------------------------------------------------
module bram_stream_reader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1600,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [ADDR_WIDTH:0]     len,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [WIDTH-1:0]        mem_din,
  input  logic [WIDTH-1:0]        mem_dout,
  bram_stream_reader_if.master    m
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [1:0]            state_r;
  logic                  busy_r, done_r, err_r;
  logic [ADDR_WIDTH-1:0] next_addr_r;    // address of the next read to issue
  logic [ADDR_WIDTH-1:0] addr_hold_r;    // last issued address, held between issues
  logic [ADDR_WIDTH:0]   remain_r;       // reads still to issue
  logic                  inflight_r;     // a read issued last cycle returns on mem_dout now
  logic                  inflight_last_r;
  logic [WIDTH-1:0]      fifo_data0_r, fifo_data1_r;  // entry 0 is the head
  logic                  fifo_last0_r, fifo_last1_r;
  logic [1:0]            count_r;

  logic                  legal_s, accept_s, pop_s, issue_s, last_pop_s;
  logic [2:0]            occ_s;

  assign mem_we  = 1'b0;
  assign mem_din = {WIDTH{1'b0}};
  assign busy    = busy_r;
  assign done    = done_r;
  assign err     = err_r;
  assign m.valid = (count_r != 2'd0);
  assign m.data  = fifo_data0_r;
  assign m.last  = (count_r != 2'd0) & fifo_last0_r;

  // Command legality, pop, and read-issue decision; mem_addr follows the issue
  // combinationally so the read lands in the same cycle it is decided.
  always_comb begin
    legal_s    = ({1'b0, base_addr} < DEPTH_L) && (len <= DEPTH_L);
    accept_s   = (state_r == ST_IDLE) && start && legal_s;
    pop_s      = (count_r != 2'd0) && m.ready;
    last_pop_s = pop_s && fifo_last0_r;
    // Words already buffered plus the one returning now, less the one leaving.
    occ_s      = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    if ((state_r == ST_RUN) && (remain_r != LEN_ZERO) && (occ_s < 3'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if (issue_s) begin
      mem_addr = next_addr_r;
    end else begin
      mem_addr = addr_hold_r;
    end
  end

  // Control FSM: command acceptance/rejection, busy/done/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
          if (start) begin
            if (!legal_s) begin
              err_r <= 1'b1;
            end else if (len == LEN_ZERO) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (last_pop_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read address generation with wrap at DEPTH, remaining count, and in-flight tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      next_addr_r     <= ADDR_ZERO;
      addr_hold_r     <= ADDR_ZERO;
      remain_r        <= LEN_ZERO;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s && (remain_r == LEN_ONE);
      if (accept_s) begin
        next_addr_r <= base_addr;
        remain_r    <= len;
      end else if (issue_s) begin
        addr_hold_r <= next_addr_r;
        remain_r    <= remain_r - LEN_ONE;
        if (next_addr_r == ADDR_LAST) begin
          next_addr_r <= ADDR_ZERO;
        end else begin
          next_addr_r <= next_addr_r + ADDR_ONE;
        end
      end
    end
  end

  // Two-entry output buffer; entry 0 only changes on a pop or when empty, so the
  // head stays stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_data0_r <= {WIDTH{1'b0}};
      fifo_data1_r <= {WIDTH{1'b0}};
      fifo_last0_r <= 1'b0;
      fifo_last1_r <= 1'b0;
      count_r      <= 2'd0;
    end else begin
      case ({inflight_r, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            fifo_data0_r <= mem_dout;
            fifo_last0_r <= inflight_last_r;
          end else begin
            fifo_data1_r <= mem_dout;
            fifo_last1_r <= inflight_last_r;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          fifo_data0_r <= fifo_data1_r;
          fifo_last0_r <= fifo_last1_r;
          count_r      <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            fifo_data0_r <= mem_dout;
            fifo_last0_r <= inflight_last_r;
          end else begin
            fifo_data0_r <= fifo_data1_r;
            fifo_last0_r <= fifo_last1_r;
            fifo_data1_r <= mem_dout;
            fifo_last1_r <= inflight_last_r;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_bram_stream_reader
// Self-checking bench: a table of directed transfers, hand-written reset and
// reset-mid-transfer sequences, then randomized transfers. Expected words come
// from a behavioural RAM model: word k = mem[(base+k) mod DEPTH].
// -----------------------------------------------------------------------------
module tb_bram_stream_reader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1600;
  localparam int AW    = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start;
  logic [AW-1:0]    base_addr;
  logic [AW:0]      xfer_len;
  logic             busy, done, err, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_din, mem_dout;
  logic [WIDTH-1:0] mem [0:DEPTH-1];

  int vectors     = 0;
  int miscompares = 0;

  bram_stream_reader_if #(.WIDTH(WIDTH)) s_if ();

  bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(xfer_len),
    .busy(busy), .done(done), .err(err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .m(s_if)
  );

  // RAM model: registered read, data valid the cycle after the address.
  always @(posedge clk) begin
    if (int'(mem_addr) < DEPTH) mem_dout <= mem[mem_addr];
    else                        mem_dout <= 32'hDEAD_BEEF;
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            rmode;    // 0: ready high, 1: 1,0,0,1,0,1 pattern, 2: random
    bit            poke;     // assert start while busy
    bit            exp_err;  // expected: command rejected
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int cyc);
    int ph;
    ph = cyc % 6;
    if (mode == 0) return 1'b1;
    if (mode == 1) return (ph == 0 || ph == 3 || ph == 5);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_xfer(input logic [AW-1:0] b, input logic [AW:0] n,
                          input int rmode, input bit poke, input bit exp_err);
    int nlen, hs, issued, ahead, max_ahead, first_valid, done_cyc, err_cyc;
    int busy_cnt, done_cnt, err_cnt, valid_cnt, term, limit, cyc;
    bit prev_stall, prev_busy;
    logic [WIDTH-1:0] prev_data;
    logic [WIDTH-1:0] expq[$];
    nlen = int'(n);
    for (int k = 0; k < nlen; k++) expq.push_back(mem[(int'(b) + k) % DEPTH]);
    hs = 0; issued = 0; max_ahead = 0; first_valid = -1; done_cyc = -1; err_cyc = -1;
    busy_cnt = 0; done_cnt = 0; err_cnt = 0; valid_cnt = 0; term = -1;
    prev_stall = 1'b0; prev_busy = 1'b0; prev_data = '0;
    limit = nlen * 8 + 30;
    // cycle 0: command
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; xfer_len = n; s_if.ready = rdy(rmode, 0);
    @(negedge clk);
    for (cyc = 1; cyc <= limit; cyc++) begin
      @(posedge clk); #1;
      start = poke && prev_busy;
      if (poke) begin
        base_addr = AW'($urandom_range(0, DEPTH - 1));
        xfer_len  = (AW+1)'($urandom_range(1, DEPTH));
      end
      s_if.ready = rdy(rmode, cyc);
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (err)  begin err_cnt++;  if (err_cyc < 0)  err_cyc = cyc;  end
      if (s_if.valid) valid_cnt++;
      if (prev_stall) begin
        chk("stall_valid", 32'(s_if.valid), 32'd1);
        chk("stall_data", s_if.data, prev_data);
      end
      if (busy && issued < nlen && int'(mem_addr) == (int'(b) + issued) % DEPTH) issued++;
      if (s_if.valid && first_valid < 0) first_valid = cyc;
      if (s_if.valid && s_if.ready) begin
        if (hs < nlen) begin
          chk("word_data", s_if.data, expq[hs]);
          chk("word_last", 32'(s_if.last), 32'(hs == nlen - 1));
        end else begin
          chk("extra_word", 32'(hs), 32'(nlen));
        end
        hs++;
      end
      ahead = issued - hs;
      if (ahead > max_ahead) max_ahead = ahead;
      prev_stall = s_if.valid && !s_if.ready;
      prev_data  = s_if.data;
      prev_busy  = busy;
      if (term < 0 && (done_cyc >= 0 || err_cyc >= 0)) term = cyc;
      if (term >= 0 && cyc >= term + 2) break;
    end
    start = 1'b0;
    chk("terminated", 32'(term >= 0), 32'd1);
    chk("mem_we_zero", {31'd0, mem_we}, 32'd0);
    if (exp_err) begin
      chk("err_cycle", 32'(err_cyc), 32'd1);
      chk("err_count", 32'(err_cnt), 32'd1);
      chk("err_no_busy", 32'(busy_cnt), 32'd0);
      chk("err_no_done", 32'(done_cnt), 32'd0);
      chk("err_no_valid", 32'(valid_cnt), 32'd0);
    end else begin
      chk("no_err", 32'(err_cnt), 32'd0);
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("word_count", 32'(hs), 32'(nlen));
      chk("addr_sequence", 32'(issued), 32'(nlen));
      chk("max_ahead_le2", 32'(max_ahead <= 2), 32'd1);
      if (rmode == 0) begin
        chk("first_valid_cyc", 32'(first_valid), (nlen == 0) ? -32'sd1 : 32'd3);
        chk("done_cyc", 32'(done_cyc), (nlen == 0) ? 32'd1 : 32'(nlen + 3));
        chk("busy_cycles", 32'(busy_cnt), (nlen == 0) ? 32'd0 : 32'(nlen + 2));
      end else begin
        chk("busy_cycles", 32'(busy_cnt), 32'(done_cyc - 1));
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_err"},   32'(err),  32'd0);
    chk({tag, "_we"},    32'(mem_we), 32'd0);
    chk({tag, "_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_din"},   mem_din, 32'd0);
    chk({tag, "_valid"}, 32'(s_if.valid), 32'd0);
    chk({tag, "_data"},  s_if.data, 32'd0);
    chk({tag, "_last"},  32'(s_if.last), 32'd0);
  endtask

  initial begin
    vec_t vt [10];
    int hs, seen;
    logic [AW-1:0] rb;
    logic [AW:0]   rn;

    vt[0] = '{base: 11'd10,   len: 12'd4,    rmode: 0, poke: 1'b0, exp_err: 1'b0}; // basic
    vt[1] = '{base: 11'd10,   len: 12'd4,    rmode: 1, poke: 1'b0, exp_err: 1'b0}; // backpressure
    vt[2] = '{base: 11'd1598, len: 12'd4,    rmode: 0, poke: 1'b0, exp_err: 1'b0}; // wrap
    vt[3] = '{base: 11'd0,    len: 12'd0,    rmode: 0, poke: 1'b0, exp_err: 1'b0}; // len 0
    vt[4] = '{base: 11'd0,    len: 12'd1600, rmode: 0, poke: 1'b0, exp_err: 1'b0}; // full RAM
    vt[5] = '{base: 11'd1600, len: 12'd4,    rmode: 0, poke: 1'b0, exp_err: 1'b1}; // bad base
    vt[6] = '{base: 11'd5,    len: 12'd1601, rmode: 0, poke: 1'b0, exp_err: 1'b1}; // bad len
    vt[7] = '{base: 11'd100,  len: 12'd6,    rmode: 0, poke: 1'b1, exp_err: 1'b0}; // start while busy
    vt[8] = '{base: 11'd1590, len: 12'd20,   rmode: 2, poke: 1'b0, exp_err: 1'b0}; // wrap + random ready
    vt[9] = '{base: 11'd0,    len: 12'd1,    rmode: 1, poke: 1'b1, exp_err: 1'b0}; // single word

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[10 + i] = 32'h0000_00A0 + 32'(i);

    rst = 1'b1; start = 1'b0; base_addr = '0; xfer_len = '0; s_if.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    for (int i = 0; i < 10; i++) run_xfer(vt[i].base, vt[i].len, vt[i].rmode, vt[i].poke, vt[i].exp_err);

    // Reset after two handshakes of an 8-word transfer.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 11'd200; xfer_len = 12'd8; s_if.ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      @(negedge clk);
      if (s_if.valid && s_if.ready) hs++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("rst_mid_two_hs", 32'(hs), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || s_if.valid || busy) seen++;
    end
    chk("rst_mid_quiet", 32'(seen), 32'd0);
    run_xfer(11'd300, 12'd5, 0, 1'b0, 1'b0);

    // Randomized transfers against the memory model.
    for (int i = 0; i < 25; i++) begin
      rb = AW'($urandom_range(0, DEPTH - 1));
      rn = (AW+1)'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) rb = AW'($urandom_range(DEPTH, 2047));
        else                           rn = (AW+1)'($urandom_range(DEPTH + 1, 4095));
      end
      run_xfer(rb, rn, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
               !((int'(rb) < DEPTH) && (int'(rn) <= DEPTH)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side controller for the single-port block RAM used across the design. On a `start` command it streams `len` consecutive words from the RAM, beginning at `base_addr`, onto a valid/ready output stream. It absorbs the RAM's one-cycle registered read latency and downstream backpressure with a two-entry output buffer, so it sustains one word per cycle. It drives the RAM's `we`, `addr` and `din` ports directly and consumes its `dout`.

## Interface
Parameters:
- `WIDTH`, 32: data word width; matches the RAM.
- `DEPTH`, 1600: RAM depth in words; address wrap point.
- `ADDR_WIDTH`, 11: RAM address width.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first word address; captured with `start`.
- `len`  in  ADDR_WIDTH+1  number of words, 0..DEPTH; captured with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` through the cycle before `done`.
- `done`  out  1  one-cycle pulse on transfer completion.
- `err`  out  1  one-cycle pulse when `start` is rejected.
- `mem_we`  out  1  RAM write enable; constant 0.
- `mem_addr`  out  ADDR_WIDTH  RAM address.
- `mem_din`  out  WIDTH  RAM write data; constant 0.
- `mem_dout`  in  WIDTH  RAM read data; valid the cycle after `mem_addr` is presented.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  WIDTH  output word.
- `m_last`  out  1  high with the final word of a transfer.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 with `base_addr` < DEPTH and `len` <= DEPTH: capture both and go to RUN. If `len`=0, go to DONE instead.
  - `start`=1 with `base_addr` >= DEPTH or `len` > DEPTH: pulse `err` the next cycle and stay in IDLE.
- **RUN, read issue**
  - A read is issued (`mem_addr` = next address) in any cycle where words remain to issue and (buffer count + reads in flight − pop this cycle) < 2.
  - The pop term combinationally uses `m_valid & m_ready`.
  - Address increments by 1 per issued read. After DEPTH−1 it wraps to 0, not to 2^ADDR_WIDTH.
- **RUN, capture**
  - Data of a read issued in cycle t is written into the two-entry FIFO at the end of cycle t+1.
  - The FIFO never overflows under the issue rule.
- **RUN, stream**
  - `m_valid` = FIFO non-empty; `m_data` = FIFO head.
  - Handshake occurs when `m_valid & m_ready`.
  - `m_valid` and `m_data` stay stable while `m_valid & !m_ready`.
  - `m_last` is high on the word whose index is `len`−1.
- **RUN exit:** the handshake of the last word moves the FSM to DONE.
- **DONE:** `done`=1 and `busy`=0 for one cycle, then return to IDLE.
- `start` is ignored while in RUN or DONE.
- `mem_addr` holds its last value when no read is issued; the extra RAM reads this causes are harmless.
- **Reset:** in the cycle after `rst`=1, all outputs are 0, including `mem_addr`. The FIFO and in-flight tracking are cleared, the FSM is in IDLE, and any mid-transfer data is discarded with no `done`.

## Timing
- Let cycle 0 be the cycle where `start` is sampled high in IDLE.
  - Cycle 1: `busy`=1, `mem_addr`=`base_addr`.
  - Cycle 2: `mem_dout` = mem[`base_addr`].
  - Cycle 3: `m_valid`=1 with word 0.
- With `m_ready` held high, word k appears in cycle 3+k.
- `done` pulses in the cycle after the last handshake.
- For `len`=0, `done` pulses in cycle 1 and `busy` never rises.
- Throughput: 1 word/cycle with `m_ready`=1. After `m_ready` recovers, streaming resumes with no bubble.
- `err` pulses in cycle 1; `busy` stays 0.

## Test plan
- **Basic:** preload mem[10..13]=A0..A3; `base_addr`=10, `len`=4, `m_ready`=1 → A0..A3 in cycles 3–6, `m_last` in cycle 6, `done` in cycle 7, `busy` high in cycles 1–6.
- **Backpressure:** same transfer with `m_ready` toggling 1,0,0,1,0,1,… → every word delivered exactly once and in order. `m_data` is stable while stalled, and `mem_addr` never advances more than 2 words ahead of the handshake count.
- **Wrap:** `base_addr`=1598, `len`=4 → `mem_addr` sequence 1598, 1599, 0, 1; data matches mem at those addresses.
- **Edge lengths:**
  - `len`=0 → `done` in cycle 1, no `m_valid`.
  - `len`=1600, `base_addr`=0 → 1600 words, `m_last` on word 1599.
- **Illegal and ignored commands:**
  - `base_addr`=1600 → `err` pulse in cycle 1, no `busy`, no `m_valid`.
  - `len`=1601 → same.
  - `start` asserted while `busy` → ignored; the current transfer completes unchanged.
- **Reset mid-transfer:** assert `rst` after 2 handshakes of a `len`=8 transfer → the next cycle has all outputs 0 and no `done`. A new `start` then runs correctly from its own `base_addr`.
